// File: rtl/multicycle_pc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, op_class codes, pc_src codes.
// Also holds the helper that picks the PC source for an instruction.
package multicycle_pc_ctrl_pkg;

   localparam logic [3:0] S_INIT = 4'd0;
   localparam logic [3:0] S_IF   = 4'd1;
   localparam logic [3:0] S_IW   = 4'd2;
   localparam logic [3:0] S_ID   = 4'd3;
   localparam logic [3:0] S_EX   = 4'd4;
   localparam logic [3:0] S_ST   = 4'd5;
   localparam logic [3:0] S_LD   = 4'd6;
   localparam logic [3:0] S_RDW  = 4'd7;
   localparam logic [3:0] S_WB   = 4'd8;

   typedef enum logic [2:0] {
      OP_R   = 3'd0,
      OP_I   = 3'd1,
      OP_LD  = 3'd2,
      OP_ST  = 3'd3,
      OP_BR  = 3'd4,
      OP_J   = 3'd5,
      OP_JAL = 3'd6,
      OP_NOP = 3'd7
   } op_class_e;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;

   function automatic logic [1:0] pc_src_for(input logic [2:0] op, input logic taken);
      if (op == OP_BR && taken)
         return PC_BR;
      else if (op == OP_J || op == OP_JAL)
         return PC_JMP;
      else
         return PC_SEQ;
   endfunction

endpackage

// File: rtl/multicycle_pc_ctrl_perf_counter.sv
// Free-running enable counter used for the controller's optional performance counters.
// Wraps modulo 2^W; synchronous active-high reset clears it.
module multicycle_pc_ctrl_perf_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/multicycle_pc_ctrl.sv
// Main FSM of the multi-cycle CPU: fetch, decode, execute, memory and writeback sequencing.
// Optional cycle/instruction counters are built only when PERF_CNT_EN is defined.
//
//  state  | meaning
//  INIT   | post-reset idle, leaves unconditionally
//  IF     | instruction fetch request outstanding
//  IW     | waiting for instruction data, latch IR
//  ID     | decode; NOP retires here
//  EX     | execute, PC update
//  ST     | store request outstanding
//  LD     | load request outstanding
//  RDW    | waiting for load data
//  WB     | register file write
module multicycle_pc_ctrl
   import multicycle_pc_ctrl_pkg::*;
#(
   parameter int PC_SRC_W = 2,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          op_class,
   input  logic                branch_taken,
   input  logic                inst_req_ready,
   input  logic                inst_valid,
   input  logic                mem_req_ready,
   input  logic                read_data_valid,
   output logic                inst_req_valid,
   output logic                inst_ready,
   output logic                ir_wen,
   output logic                mem_read,
   output logic                mem_write,
   output logic                read_data_ready,
   output logic                pc_write,
   output logic [PC_SRC_W-1:0] pc_src,
   output logic                rf_wen,
   output logic [3:0]          state_o
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    inst_cnt
`endif
);

   logic [3:0]          state;
   logic [3:0]          state_nxt;
   logic [PC_SRC_W-1:0] pc_src_q;
   logic                nop_retire;

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT: state_nxt = S_IF;
         S_IF:   if (inst_req_ready)  state_nxt = S_IW;
         S_IW:   if (inst_valid)      state_nxt = S_ID;
         S_ID:   state_nxt = (op_class == OP_NOP) ? S_IF : S_EX;
         S_EX: begin
            case (op_class)
               OP_LD:                    state_nxt = S_LD;
               OP_ST:                    state_nxt = S_ST;
               OP_BR, OP_J, OP_NOP:      state_nxt = S_IF;
               default:                  state_nxt = S_WB;
            endcase
         end
         S_ST:   if (mem_req_ready)   state_nxt = S_IF;
         S_LD:   if (mem_req_ready)   state_nxt = S_RDW;
         S_RDW:  if (read_data_valid) state_nxt = S_WB;
         S_WB:   state_nxt = S_IF;
         default: state_nxt = S_INIT;
      endcase
   end

   assign inst_req_valid  = (state == S_IF);
   assign inst_ready      = (state == S_IW);
   assign ir_wen          = inst_ready & inst_valid;
   assign mem_read        = (state == S_LD);
   assign mem_write       = (state == S_ST);
   assign read_data_ready = (state == S_RDW);
   assign rf_wen          = (state == S_WB);
   assign state_o         = state;

   // A NOP retires from ID, so it carries the PC update that EX would otherwise make.
   assign nop_retire = (state == S_ID) && (op_class == OP_NOP);
   assign pc_write   = (state == S_EX) || nop_retire;
   assign pc_src     = pc_write ? PC_SRC_W'(pc_src_for(op_class, branch_taken)) : pc_src_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_INIT;
         pc_src_q <= '0;
      end else begin
         state <= state_nxt;
         if (pc_write)
            pc_src_q <= pc_src;
      end
   end

`ifdef PERF_CNT_EN
   multicycle_pc_ctrl_perf_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .cnt (cycle_cnt)
   );

   multicycle_pc_ctrl_perf_counter #(.W(CNT_W)) u_inst_cnt (
      .clk (clk),
      .rst (rst),
      .en  (pc_write),
      .cnt (inst_cnt)
   );
`endif

endmodule

// File: tb/tb_multicycle_pc_ctrl.sv
// Scoreboard bench for multicycle_pc_ctrl: each entry is one cycle of stimulus plus the
// state and outputs expected in that cycle; tasks queue entries, then pop and compare.
module tb_multicycle_pc_ctrl;
   import multicycle_pc_ctrl_pkg::*;

   logic       clk;
   logic       rst;
   logic [2:0] op_class;
   logic       branch_taken, inst_req_ready, inst_valid, mem_req_ready, read_data_valid;
   logic       inst_req_valid, inst_ready, ir_wen, mem_read, mem_write, read_data_ready;
   logic       pc_write, rf_wen;
   logic [1:0] pc_src;
   logic [3:0] state_o;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, inst_cnt;
`endif

   multicycle_pc_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .op_class        (op_class),
      .branch_taken    (branch_taken),
      .inst_req_ready  (inst_req_ready),
      .inst_valid      (inst_valid),
      .mem_req_ready   (mem_req_ready),
      .read_data_valid (read_data_valid),
      .inst_req_valid  (inst_req_valid),
      .inst_ready      (inst_ready),
      .ir_wen          (ir_wen),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .read_data_ready (read_data_ready),
      .pc_write        (pc_write),
      .pc_src          (pc_src),
      .rf_wen          (rf_wen),
      .state_o         (state_o)
`ifdef PERF_CNT_EN
      ,
      .cycle_cnt       (cycle_cnt),
      .inst_cnt        (inst_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {inst_req_valid, inst_ready, ir_wen, mem_read, mem_write, read_data_ready, pc_write, pc_src[1:0], rf_wen}
   logic [9:0] obs;
   assign obs = {inst_req_valid, inst_ready, ir_wen, mem_read, mem_write, read_data_ready,
                 pc_write, pc_src, rf_wen};

   localparam logic [9:0] O_NONE = 10'b0000000000;
   localparam logic [9:0] O_IF   = 10'b1000000000;
   localparam logic [9:0] O_IW   = 10'b0110000000;
   localparam logic [9:0] O_IWH  = 10'b0100000000;
   localparam logic [9:0] O_LD   = 10'b0001000000;
   localparam logic [9:0] O_ST   = 10'b0000100000;
   localparam logic [9:0] O_RDW  = 10'b0000010000;
   localparam logic [9:0] O_PW   = 10'b0000001000;
   localparam logic [9:0] O_WB   = 10'b0000000001;

   function automatic logic [9:0] ps(input logic [1:0] s);
      return {7'b0, s, 1'b0};
   endfunction

   typedef struct {
      logic       rst;
      logic [2:0] op;
      logic       bt, irr, iv, mrr, rdv;
      logic       chk;
      logic [3:0] st;
      logic [9:0] o;
   } ent_t;

   ent_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic void push(input logic r, input logic [2:0] op, input logic bt,
                                input logic irr, input logic iv, input logic mrr, input logic rdv,
                                input logic chk, input logic [3:0] st, input logic [9:0] o);
      ent_t e;
      e = '{r, op, bt, irr, iv, mrr, rdv, chk, st, o};
      sb.push_back(e);
   endfunction

   // Cycle with all readies/valids high and rst low.
   function automatic void fr(input logic [2:0] op, input logic bt, input logic [3:0] st,
                              input logic [9:0] o);
      push(1'b0, op, bt, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, st, o);
   endfunction

   function automatic void rst_cycle();
      push(1'b1, OP_R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, S_INIT, O_NONE);
   endfunction

   task automatic apply(input ent_t e);
      @(posedge clk);
      #1;
      rst = e.rst; op_class = e.op; branch_taken = e.bt; inst_req_ready = e.irr;
      inst_valid = e.iv; mem_req_ready = e.mrr; read_data_valid = e.rdv;
      @(negedge clk);
   endtask

   task automatic test_reset();
      ent_t e;
      int   i = 0;
      for (int k = 0; k < 3; k++) push(1'b1, OP_R, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, S_INIT, O_NONE);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         apply(e);
         if (e.chk) begin
            n_chk++;
            if ({state_o, obs} !== {e.st, e.o}) begin
               n_fail++;
               $display("FAIL reset cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                        i, state_o, obs, e.st, e.o);
            end
         end
         i++;
      end
   endtask

   task automatic test_r_type();
      ent_t e;
      int   i = 0;
      // branch_taken high on an R-type must not select the branch target
      fr(OP_R, 1'b1, S_INIT, O_NONE);
      fr(OP_R, 1'b1, S_IF,   O_IF);
      fr(OP_R, 1'b1, S_IW,   O_IW);
      fr(OP_R, 1'b1, S_ID,   O_NONE);
      fr(OP_R, 1'b1, S_EX,   O_PW | ps(PC_SEQ));
      fr(OP_R, 1'b1, S_WB,   O_WB);
      fr(OP_R, 1'b1, S_IF,   O_IF);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         apply(e);
         if (e.chk) begin
            n_chk++;
            if ({state_o, obs} !== {e.st, e.o}) begin
               n_fail++;
               $display("FAIL r_type cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                        i, state_o, obs, e.st, e.o);
            end
         end
         i++;
      end
   endtask

   task automatic test_load_stall();
      ent_t e;
      int   i = 0;
      rst_cycle();
      fr(OP_LD, 1'b0, S_INIT, O_NONE);
      fr(OP_LD, 1'b0, S_IF,   O_IF);
      fr(OP_LD, 1'b0, S_IW,   O_IW);
      fr(OP_LD, 1'b0, S_ID,   O_NONE);
      fr(OP_LD, 1'b0, S_EX,   O_PW);
      // read_data_valid arriving early in LD must be ignored
      for (int k = 0; k < 4; k++) push(1'b0, OP_LD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, S_LD, O_LD);
      push(1'b0, OP_LD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, S_LD, O_LD);
      for (int k = 0; k < 2; k++) push(1'b0, OP_LD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, S_RDW, O_RDW);
      fr(OP_LD, 1'b0, S_RDW,  O_RDW);
      fr(OP_LD, 1'b0, S_WB,   O_WB);
      fr(OP_LD, 1'b0, S_IF,   O_IF);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         apply(e);
         if (e.chk) begin
            n_chk++;
            if ({state_o, obs} !== {e.st, e.o}) begin
               n_fail++;
               $display("FAIL load_stall cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                        i, state_o, obs, e.st, e.o);
            end
         end
         i++;
      end
   endtask

   task automatic test_fetch_stall();
      ent_t e;
      int   i = 0;
      rst_cycle();
      push(1'b0, OP_ST, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_INIT, O_NONE);
      for (int k = 0; k < 10; k++) push(1'b0, OP_ST, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_IF, O_IF);
      fr(OP_ST, 1'b0, S_IF, O_IF);
      for (int k = 0; k < 2; k++) push(1'b0, OP_ST, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_IW, O_IWH);
      fr(OP_ST, 1'b0, S_IW, O_IW);
      fr(OP_ST, 1'b0, S_ID, O_NONE);
      fr(OP_ST, 1'b0, S_EX, O_PW);
      for (int k = 0; k < 2; k++) push(1'b0, OP_ST, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, S_ST, O_ST);
      fr(OP_ST, 1'b0, S_ST, O_ST);
      fr(OP_ST, 1'b0, S_IF, O_IF);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         apply(e);
         if (e.chk) begin
            n_chk++;
            if ({state_o, obs} !== {e.st, e.o}) begin
               n_fail++;
               $display("FAIL fetch_stall cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                        i, state_o, obs, e.st, e.o);
            end
         end
         i++;
      end
   endtask

   task automatic test_branch_jump();
      ent_t e;
      int   i = 0;
      rst_cycle();
      fr(OP_BR,  1'b0, S_INIT, O_NONE);
      fr(OP_BR,  1'b0, S_IF,   O_IF);
      fr(OP_BR,  1'b0, S_IW,   O_IW);
      fr(OP_BR,  1'b0, S_ID,   O_NONE);
      fr(OP_BR,  1'b1, S_EX,   O_PW | ps(PC_BR));
      fr(OP_BR,  1'b0, S_IF,   O_IF | ps(PC_BR));
      fr(OP_BR,  1'b0, S_IW,   O_IW | ps(PC_BR));
      fr(OP_BR,  1'b0, S_ID,   ps(PC_BR));
      fr(OP_BR,  1'b0, S_EX,   O_PW | ps(PC_SEQ));
      fr(OP_NOP, 1'b0, S_IF,   O_IF);
      fr(OP_NOP, 1'b0, S_IW,   O_IW);
      fr(OP_NOP, 1'b0, S_ID,   O_PW | ps(PC_SEQ));
      fr(OP_J,   1'b0, S_IF,   O_IF);
      fr(OP_J,   1'b0, S_IW,   O_IW);
      fr(OP_J,   1'b0, S_ID,   O_NONE);
      fr(OP_J,   1'b0, S_EX,   O_PW | ps(PC_JMP));
      fr(OP_JAL, 1'b0, S_IF,   O_IF | ps(PC_JMP));
      fr(OP_JAL, 1'b0, S_IW,   O_IW | ps(PC_JMP));
      fr(OP_JAL, 1'b0, S_ID,   ps(PC_JMP));
      fr(OP_JAL, 1'b0, S_EX,   O_PW | ps(PC_JMP));
      fr(OP_JAL, 1'b0, S_WB,   O_WB | ps(PC_JMP));
      fr(OP_JAL, 1'b0, S_IF,   O_IF | ps(PC_JMP));
      fr(OP_JAL, 1'b0, S_IW,   O_IW | ps(PC_JMP));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         apply(e);
         if (e.chk) begin
            n_chk++;
            if ({state_o, obs} !== {e.st, e.o}) begin
               n_fail++;
               $display("FAIL branch_jump cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                        i, state_o, obs, e.st, e.o);
            end
         end
         i++;
      end
   endtask

   task automatic test_reset_mid();
      ent_t e;
      int   i = 0;
      // pc_src was left at PC_JMP; reset must clear it
      rst_cycle();
      fr(OP_LD, 1'b0, S_INIT, O_NONE);
      fr(OP_LD, 1'b0, S_IF,   O_IF);
      fr(OP_LD, 1'b0, S_IW,   O_IW);
      fr(OP_LD, 1'b0, S_ID,   O_NONE);
      fr(OP_LD, 1'b0, S_EX,   O_PW);
      push(1'b0, OP_LD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, S_LD, O_LD);
      push(1'b1, OP_LD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, S_LD, O_LD);
      fr(OP_LD, 1'b0, S_INIT, O_NONE);
      fr(OP_LD, 1'b0, S_IF,   O_IF);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         apply(e);
         if (e.chk) begin
            n_chk++;
            if ({state_o, obs} !== {e.st, e.o}) begin
               n_fail++;
               $display("FAIL reset_mid cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                        i, state_o, obs, e.st, e.o);
            end
         end
         i++;
      end
   endtask

`ifdef PERF_CNT_EN
   task automatic test_perf();
      // INIT cycle plus five states (IF IW ID EX WB) per R-type instruction
      localparam int EXP_CYC = 1 + 10 * 5;
      @(posedge clk); #1;
      rst = 1'b1; op_class = OP_R; branch_taken = 1'b0;
      inst_req_ready = 1'b1; inst_valid = 1'b1; mem_req_ready = 1'b1; read_data_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++;
      if (cycle_cnt !== 32'd0 || inst_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got cycle_cnt=%0d inst_cnt=%0d, expected 0 and 0", cycle_cnt, inst_cnt);
      end
      repeat (EXP_CYC) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (cycle_cnt !== 32'(EXP_CYC) || inst_cnt !== 32'd10 || state_o !== S_IF) begin
         n_fail++;
         $display("FAIL perf_count: got cycle_cnt=%0d inst_cnt=%0d state=%0d, expected %0d, 10, %0d",
                  cycle_cnt, inst_cnt, state_o, EXP_CYC, S_IF);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; op_class = OP_R; branch_taken = 1'b0;
      inst_req_ready = 1'b1; inst_valid = 1'b1; mem_req_ready = 1'b1; read_data_valid = 1'b1;
      repeat (2) @(posedge clk);
      test_reset();
      test_r_type();
      test_load_stall();
      test_fetch_stall();
      test_branch_jump();
      test_reset_mid();
`ifdef PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
